data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words of storage (1 KiB).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states per access, legal range 0..15.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  initiator presents a request.
REQ-006 SHALL have port req_ready  out  1  responder can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  in  3  RISC-V load/store funct3 size/sign code.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  out  32  load result, extended to 32 bits.
REQ-014 SHALL have port rsp_err  out  1  access rejected.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept = req_valid & req_ready at a rising edge; SHALL latch we, funct3, addr, wdata and load the wait counter with WAIT_CYCLES.
REQ-018 Transitions: IDLE->WAIT on accept if WAIT_CYCLES>0, IDLE->RESP on accept if WAIT_CYCLES==0; WAIT decrements the counter and goes to RESP on the edge where the counter equals 1.
REQ-019 Latency SHALL be exactly WAIT_CYCLES+1 edges from accept edge to first cycle with rsp_valid=1.
REQ-020 Storage read/write SHALL take effect on the edge entering RESP, using only latched request values; request inputs are don't-care outside IDLE.
REQ-021 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL stay stable until rsp_valid & rsp_ready; that edge goes to IDLE.
REQ-022 No same-cycle re-accept: req_ready SHALL be 0 in the RESP cycle and 1 in the next IDLE cycle.
REQ-023 Layout little-endian: byte at addr[1:0]=k occupies word bits [8k+7:8k]; word index = addr[31:2].
REQ-024 Loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-025 Stores: 000 SB writes one byte lane, 001 SH two lanes, 010 SW all four; other lanes unchanged; rsp_rdata = 0 for stores.
REQ-026 rsp_err=1 SHALL flag any of: funct3 not in the legal set for the direction (store legal = 000/001/010), halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS.
REQ-027 On error, no storage write SHALL occur, rsp_rdata = 0, and a normal response handshake SHALL still complete.
REQ-028 Out-of-range index SHALL never wrap or alias onto valid storage.

Reset
REQ-029 On rst: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1 in the following cycle.
REQ-030 Storage contents SHALL NOT be cleared by rst.
REQ-031 A store in WAIT when rst asserts SHALL be dropped, with no partial write; a pending response in RESP SHALL be discarded.
REQ-032 rst SHALL take priority over every accept and handshake in the same cycle.

Verification
REQ-033 WAIT_CYCLES=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 3 edges after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 SB 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-035 LH 0x13 -> err=1, rdata 0; SW 0x12 -> err=1 and word 0x10 unchanged; LW 0x400 with DEPTH_WORDS=256 -> err=1.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0 throughout; handshake -> req_ready=1 next cycle.
REQ-037 Assert rst during WAIT of SW 0x20 data 0x12345678 -> next cycle IDLE, rsp_valid=0; LW 0x20 returns the prior contents.
REQ-038 WAIT_CYCLES=0: back-to-back LW with rsp_ready tied 1 -> one response every 2 cycles, latency 1 edge.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a request/response handshake for a RISC-V load/store unit.
// Each access spends WAIT_CYCLES wait states before the response is presented and held.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             acc_we_s;
  logic [2:0]       acc_f3_s;
  logic [31:0]      acc_addr_s;
  logic [31:0]      acc_wdata_s;
  logic [IDX_W-1:0] idx_s;
  logic             in_range_s, legal_s, misalign_s, err_s;
  logic [31:0]      word_s, shifted_s, load_s, store_word_s;
  logic [3:0]       be_s;
  logic             enter_resp_s, mem_we_s;

  // With zero wait states the access happens on the accept edge, so the live inputs are used there.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we_s    = req_we;
      acc_f3_s    = req_funct3;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_we_s    = we_q;
      acc_f3_s    = funct3_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
  end

  // Decode legality, extract load data and build the store lane mask.
  always_comb begin
    idx_s      = acc_addr_s[IDX_W+1:2];
    in_range_s = ({2'b00, acc_addr_s[31:2]} < 32'(DEPTH_WORDS));
    word_s     = in_range_s ? mem[idx_s] : 32'd0;
    shifted_s  = word_s >> {acc_addr_s[1:0], 3'b000};
    if (acc_we_s) begin
      legal_s = (acc_f3_s == 3'b000) || (acc_f3_s == 3'b001) || (acc_f3_s == 3'b010);
    end else begin
      legal_s = (acc_f3_s == 3'b000) || (acc_f3_s == 3'b001) || (acc_f3_s == 3'b010) ||
                (acc_f3_s == 3'b100) || (acc_f3_s == 3'b101);
    end
    if (acc_f3_s[1:0] == 2'b01) begin
      misalign_s = acc_addr_s[0];
    end else if (acc_f3_s[1:0] == 2'b10) begin
      misalign_s = (acc_addr_s[1:0] != 2'b00);
    end else begin
      misalign_s = 1'b0;
    end
    err_s = !legal_s || misalign_s || !in_range_s;
    case (acc_f3_s)
      3'b000:  load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b010:  load_s = word_s;
      3'b100:  load_s = {24'd0, shifted_s[7:0]};
      3'b101:  load_s = {16'd0, shifted_s[15:0]};
      default: load_s = 32'd0;
    endcase
    case (acc_f3_s[1:0])
      2'b00: begin
        be_s         = 4'b0001 << acc_addr_s[1:0];
        store_word_s = {4{acc_wdata_s[7:0]}};
      end
      2'b01: begin
        be_s         = 4'b0011 << acc_addr_s[1:0];
        store_word_s = {2{acc_wdata_s[15:0]}};
      end
      2'b10: begin
        be_s         = 4'b1111;
        store_word_s = acc_wdata_s;
      end
      default: begin
        be_s         = 4'b0000;
        store_word_s = 32'd0;
      end
    endcase
  end

  // Next-state logic for the handshake FSM and the response registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (enter_resp_s) begin
      err_d   = err_s;
      rdata_d = (err_s || acc_we_s) ? 32'd0 : load_s;
    end else begin
      err_d   = err_q;
      rdata_d = rdata_q;
    end
    mem_we_s = enter_resp_s && acc_we_s && !err_s;
  end

  // Control and response state; storage is deliberately outside this reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Byte-lane storage write; a reset on the same edge drops the store entirely.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem[idx_s][8*b +: 8] <= store_word_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: instance a has two wait states, instance b none; both are
// compared against a byte-addressed reference memory.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
  logic [2:0]  req_funct3_b;
  logic [31:0] req_addr_b, req_wdata_b, rsp_rdata_b;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_funct3(req_funct3_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference storage: bytes 0..1023 mirror dut, 1024..2047 mirror dut_b.
  logic [7:0] ref_bytes [2048];

  function automatic void model(input int base, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int sz;
    logic legal;
    logic [31:0] v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    er = !legal || ((addr % sz) != 0) || (addr >= 32'd1024);
    rd = 32'd0;
    if (!er && we) begin
      for (int i = 0; i < sz; i++) ref_bytes[base + int'(addr) + i] = wd[8*i +: 8];
    end else if (!er) begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v = v | (32'(ref_bytes[base + int'(addr) + i]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      rd = v;
    end
  endfunction

  // Full access on dut; called 1 time unit after a rising edge with dut idle.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_valid_b = 1'b1; rsp_ready = 1'b1; rsp_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; rsp_ready = 1'b0; rsp_ready_b = 1'b0;
    n_cmp += 6;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", rsp_err); end
    if (req_ready_b !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready_b got %b want 1", req_ready_b); end
  endtask

  task automatic test_init;
    logic [31:0] rd, erd, wd; logic er, eer; int lat;
    for (int w = 0; w < 256; w++) begin
      wd = $urandom;
      model(0, 1'b1, 3'b010, 32'(w * 4), wd, erd, eer);
      do_access(1'b1, 3'b010, 32'(w * 4), wd, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0 || lat != 3) begin
        n_bad++; $display("FAIL init_sw w=%0d err=%b lat=%0d want err=0 lat=3", w, er, lat);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] rd, erd; logic er, eer; int lat;
    logic [31:0] addrs [9] = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h11, 32'h10, 32'h13, 32'h12, 32'h400};
    logic        wes   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s   [9] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b010, 3'b010};
    logic [31:0] wds   [9] = '{32'hDEADBEEF, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h55555555, 32'h0};
    logic [31:0] exp_d [9] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF,
                               32'h0, 32'h0, 32'h0};
    logic        exp_e [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      model(0, wes[i], f3s[i], addrs[i], wds[i], erd, eer);
      do_access(wes[i], f3s[i], addrs[i], wds[i], rd, er, lat);
      n_cmp += 3;
      if (rd !== exp_d[i]) begin n_bad++; $display("FAIL directed_rdata #%0d got %h want %h", i, rd, exp_d[i]); end
      if (er !== exp_e[i]) begin n_bad++; $display("FAIL directed_err #%0d got %b want %b", i, er, exp_e[i]); end
      if (lat != 3) begin n_bad++; $display("FAIL directed_latency #%0d got %0d want 3", i, lat); end
    end
    do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDEAD80EF) begin n_bad++; $display("FAIL directed_unchanged got %h want DEAD80EF", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, addr, wd; logic er, eer, we; logic [2:0] f3; int lat, r;
    for (int i = 0; i < 300; i++) begin
      we = $urandom; f3 = 3'($urandom_range(0, 7)); wd = $urandom; r = $urandom_range(0, 9);
      addr = (r < 8) ? 32'($urandom_range(0, 1023)) : (r == 8) ? 32'($urandom_range(1024, 4095)) : $urandom;
      model(0, we, f3, addr, wd, erd, eer);
      do_access(we, f3, addr, wd, rd, er, lat);
      n_cmp += 3;
      if (rd !== erd) begin n_bad++; $display("FAIL random_rdata we=%b f3=%0d a=%h got %h want %h", we, f3, addr, rd, erd); end
      if (er !== eer) begin n_bad++; $display("FAIL random_err we=%b f3=%0d a=%h got %b want %b", we, f3, addr, er, eer); end
      if (lat != 3) begin n_bad++; $display("FAIL random_latency got %0d want 3", lat); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] erd, rd; logic eer, er; int lat;
    model(0, 1'b0, 3'b010, 32'h10, 32'h0, erd, eer);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    for (int c = 0; c < 5; c++) begin
      n_cmp += 3;
      if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid c=%0d got %b want 1", c, rsp_valid); end
      if (rsp_rdata !== erd) begin n_bad++; $display("FAIL hold_rdata c=%0d got %h want %h", c, rsp_rdata, erd); end
      if (req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_req_ready c=%0d got %b want 0", c, req_ready); end
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp += 2;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL after_hs_req_ready got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL after_hs_valid got %b want 0", rsp_valid); end
    do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== erd) begin n_bad++; $display("FAIL hold_no_store got %h want %h", rd, erd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, erd; logic er, eer; int lat;
    logic [31:0] ra [2] = '{32'h20, 32'h24};
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = ra[k]; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (k == 1) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp += 3;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_wait_busy k=%0d got %b want 0", k, busy); end
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wait_valid k=%0d got %b want 0", k, rsp_valid); end
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wait_ready k=%0d got %b want 1", k, req_ready); end
      model(0, 1'b0, 3'b010, ra[k], 32'h0, erd, eer);
      do_access(1'b0, 3'b010, ra[k], 32'h0, rd, er, lat);
      n_cmp++;
      if (rd !== erd) begin n_bad++; $display("FAIL rst_wait_dropped k=%0d got %h want %h", k, rd, erd); end
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rst = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b0;
    n_cmp += 3;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got %b want 0", rsp_valid); end
    if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_resp_rdata got %h want 0", rsp_rdata); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_resp_ready got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back;
    logic        cw [16];
    logic [2:0]  cf [16];
    logic [31:0] ca [16], cd [16];
    logic [31:0] exp_q [$];
    logic [31:0] erd; logic eer;
    logic [2:0]  lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int issued, n_rsp, last_rsp, acc_cyc;
    logic acc_prev;
    for (int i = 0; i < 16; i++) begin
      cw[i] = (i < 8); ca[i] = 32'((i % 8) * 4); cd[i] = $urandom;
      cf[i] = (i < 8) ? 3'b010 : lf[$urandom_range(0, 4)];
    end
    issued = 0; n_rsp = 0; last_rsp = -1; acc_cyc = -10;
    rsp_ready_b = 1'b1;
    req_valid_b = 1'b1; req_we_b = cw[0]; req_funct3_b = cf[0]; req_addr_b = ca[0]; req_wdata_b = cd[0];
    acc_prev = req_valid_b && req_ready_b;
    for (int cyc = 1; cyc <= 60 && n_rsp < 16; cyc++) begin
      @(posedge clk); #1;
      if (acc_prev) begin
        model(1024, cw[issued], cf[issued], ca[issued], cd[issued], erd, eer);
        exp_q.push_back(erd);
        acc_cyc = cyc; issued++;
      end
      if (rsp_valid_b) begin
        erd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        n_cmp += 3;
        if (rsp_rdata_b !== erd) begin n_bad++; $display("FAIL b2b_rdata n=%0d got %h want %h", n_rsp, rsp_rdata_b, erd); end
        if (cyc != acc_cyc) begin n_bad++; $display("FAIL b2b_latency n=%0d got %0d want 1", n_rsp, cyc - acc_cyc + 1); end
        if (req_ready_b !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_in_resp n=%0d got %b want 0", n_rsp, req_ready_b); end
        if (last_rsp >= 0) begin
          n_cmp++;
          if (cyc - last_rsp != 2) begin n_bad++; $display("FAIL b2b_spacing n=%0d got %0d want 2", n_rsp, cyc - last_rsp); end
        end
        last_rsp = cyc; n_rsp++;
      end
      if (issued < 16) begin
        req_valid_b = 1'b1; req_we_b = cw[issued]; req_funct3_b = cf[issued];
        req_addr_b = ca[issued]; req_wdata_b = cd[issued];
      end else begin
        req_valid_b = 1'b0;
      end
      acc_prev = req_valid_b && req_ready_b;
    end
    req_valid_b = 1'b0;
    n_cmp++;
    if (n_rsp != 16) begin n_bad++; $display("FAIL b2b_count got %0d want 16", n_rsp); end
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; rsp_ready_b = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_funct3_b = 3'd0; req_addr_b = 32'd0; req_wdata_b = 32'd0;
    test_reset();
    test_init();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
